nios_system_timer_sequencer: RTL

- Avalon-MM master FSM that owns the interval-timer slave (16-bit data, 3-bit word address, registered readdata, level irq).
- Configures the timer, arms it, services every timeout interrupt (clear plus read-back check), and divides timeouts into a one-cycle `tick` strobe.
- `tick` paces the audio filter's coefficient/housekeeping scheduler without CPU involvement.
- Sits between the timer slave and the filter control logic.

---
 rtl/timer_seq_pkg.sv | 23 ++
 rtl/timer_tick_divider.sv | 50 +++++
 rtl/nios_system_timer_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/timer_seq_pkg.sv
// Shared types and timer register map for the interval-timer service sequencer.
// No logic; state encoding, word addresses and control bit positions only.
package timer_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    ARM,
    WAIT_IRQ,
    CLR,
    RD_ADDR,
    RD_CAP,
    DIS
  } state_e;

  localparam logic [2:0] TMR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_PERIODH = 3'd3;

  localparam int CTRL_ITO = 0;

endpackage

// File: rtl/timer_tick_divider.sv
// Divides serviced timeout events into a one-cycle tick and counts ticks issued.
// tick rises the cycle after the TICK_DIV-th event; never stalls, no backpressure.
module timer_tick_divider #(
  parameter int TICK_DIV = 48,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             event_strobe,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count
);

  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

  logic [15:0]      div_q, div_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    cnt_d  = cnt_q;
    if (event_strobe) begin
      if (div_q == DIV_LAST) begin
        div_d  = 16'd0;
        tick_d = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
      end else begin
        div_d = div_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= 16'd0;
      tick_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      cnt_q  <= cnt_d;
    end
  end

  assign tick       = tick_q;
  assign tick_count = cnt_q;

endmodule

// File: rtl/nios_system_timer_sequencer.sv
// Avalon-MM master that configures, arms and services the interval timer, emitting a paced tick.
// Clear write the cycle after irq, read-back 3 cycles after irq; timer has no wait states.
module nios_system_timer_sequencer
  import timer_seq_pkg::*;
#(
  parameter int TICK_DIV = 48,
  parameter int CNT_W    = 16,
  parameter int OVR_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [2:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [15:0]      m_writedata,
  input  logic [15:0]      m_readdata,
  input  logic             m_irq,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic [OVR_W-1:0] overrun_count,
  output logic             running
);

  state_e           state_q, state_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;
  logic             event_strobe;
  logic             ovr_inc;
  logic             unused_rdata;

  // Only the timeout flag of the status word matters here.
  assign unused_rdata = ^m_readdata[15:1];

  always_comb begin
    state_d      = state_q;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_address    = TMR_STATUS;
    m_writedata  = 16'h0000;
    event_strobe = 1'b0;
    ovr_inc      = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = CFG;
      end
      CFG: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = TMR_CONTROL;
        m_writedata  = 16'(1) << CTRL_ITO;
        state_d      = ARM;
      end
      ARM: begin
        // Period write reloads the counter; the following clear drops any stale timeout.
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = TMR_PERIODL;
        state_d      = CLR;
      end
      WAIT_IRQ: begin
        if (!enable) begin
          state_d = DIS;
        end else if (m_irq) begin
          event_strobe = 1'b1;
          state_d      = CLR;
        end
      end
      CLR: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = TMR_STATUS;
        state_d      = RD_ADDR;
      end
      RD_ADDR: begin
        state_d = RD_CAP;
      end
      RD_CAP: begin
        if (m_readdata[0]) begin
          ovr_inc      = 1'b1;
          event_strobe = 1'b1;
          state_d      = CLR;
        end else if (enable) begin
          state_d = WAIT_IRQ;
        end else begin
          state_d = DIS;
        end
      end
      DIS: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = TMR_CONTROL;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovr_d = ovr_q;
    if (ovr_inc && (ovr_q != {OVR_W{1'b1}})) ovr_d = ovr_q + OVR_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      ovr_q   <= ovr_d;
    end
  end

  assign running = (state_q == WAIT_IRQ) || (state_q == CLR) ||
                   (state_q == RD_ADDR)  || (state_q == RD_CAP);
  assign overrun_count = ovr_q;

  timer_tick_divider #(
    .TICK_DIV(TICK_DIV),
    .CNT_W   (CNT_W)
  ) u_div (
    .clk         (clk),
    .reset_n     (reset_n),
    .event_strobe(event_strobe),
    .tick        (tick),
    .tick_count  (tick_count)
  );

endmodule
